multi_digit_display_driver: RTL and testbench
=============================================

MULTI_DIGIT_DISPLAY_DRIVER -- requirements
Module: multi_digit_display_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter SUBSLOT_DIV, default 390: CLK cycles per brightness sub-phase, >=1; one digit slot = 16*SUBSLOT_DIV cycles.
REQ-003 The module SHALL have one clock; reset is synchronous and active-high.
REQ-004 CLK  input  1  system clock (100 MHz board clock); all state on rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 LOAD  input  1  single-cycle strobe; samples DIGIT_IN/DOT_IN.
REQ-007 DIGIT_IN  input  4*NUM_DIGITS  hex nibbles, digit k = DIGIT_IN[4k+3:4k], digit 0 rightmost.
REQ-008 DOT_IN  input  NUM_DIGITS  decimal point per digit, 1 = lit.
REQ-009 BRIGHTNESS  input  4  duty level, 0 = 1/16 on, 15 = fully on.
REQ-010 BLANK_EN  input  1  run-time leading-zero blanking request.
REQ-011 BUSY  output  1  high while a loaded value waits for frame boundary.
REQ-012 HEX_OUT  output  8  active-low segments, bit0=a..bit6=g, bit7=dp.
REQ-013 SEG_SELECT  output  NUM_DIGITS  active-low anode enables, one-hot-low or all high.

Function
REQ-014 Prescaler SHALL count 0..16*SUBSLOT_DIV-1 and wrap; slot tick = cycle where prescaler is at maximum.
REQ-015 Digit index SHALL advance on slot tick, wrapping NUM_DIGITS-1 -> 0; frame boundary = slot tick with index NUM_DIGITS-1.
REQ-016 LOAD SHALL capture DIGIT_IN and DOT_IN into a pending register and set BUSY next cycle; a later LOAD before the boundary overwrites pending.
REQ-017 At frame boundary with BUSY high, pending SHALL copy to the display register and BUSY clear in the same edge.
REQ-018 LOAD coincident with frame boundary: DIGIT_IN/DOT_IN SHALL go directly to the display register, BUSY ends low.
REQ-019 Display register SHALL never change except at a frame boundary (no tearing within a frame).
REQ-020 Sub-phase = prescaler / SUBSLOT_DIV (0..15); current anode SHALL be driven low only while sub-phase <= BRIGHTNESS, else all SEG_SELECT high.
REQ-021 Segment decode SHALL be standard hex 0-F (0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E with dp=1), bit7 = ~dot.
REQ-022 HEX_OUT and SEG_SELECT SHALL be registered: one cycle latency from index/sub-phase to pins.
REQ-023 BRIGHTNESS and BLANK_EN changes SHALL take effect from the next cycle; no handshake.

Reset
REQ-024 RESET SHALL clear prescaler, digit index, pending and display registers, and BUSY on the next edge, overriding LOAD.
REQ-025 During and one cycle after RESET, HEX_OUT SHALL be 8'hFF and SEG_SELECT all ones.
REQ-026 RESET asserted mid-frame SHALL restart scanning at digit 0, prescaler 0, discarding any pending value.

Configuration
REQ-027 Macro LEADING_ZERO_BLANK_EN defined: with BLANK_EN high, each digit k>=1 whose nibble and all higher nibbles are zero SHALL output segments a-g off (HEX_OUT[6:0]=7'h7F), dp still per dot; digit 0 never blanked.
REQ-028 Macro LEADING_ZERO_BLANK_EN undefined: blanking logic absent, BLANK_EN ignored, all digits always decoded.

Verification (NUM_DIGITS=4, SUBSLOT_DIV=2, slot = 32 cycles)
REQ-029 Reset, LOAD 16'h1234 DOT 0 -> after first boundary digits 0..3 show 99/B0/A4/F9 with SEG_SELECT 1110/1101/1011/0111, BRIGHTNESS=15 anode low 32 of 32 cycles.
REQ-030 Display 16'h1234, LOAD 16'hABCD at digit 1 mid-slot -> BUSY high, digits 1-3 still show 1234 values, 16'hABCD (A1/C6/83/88) visible from next frame, BUSY low after boundary.
REQ-031 BRIGHTNESS=3 -> each slot anode low exactly 8 cycles (sub-phases 0-3), high 24; HEX_OUT still valid.
REQ-032 LEADING_ZERO_BLANK_EN defined, BLANK_EN=1, LOAD 16'h0050 DOT 4'b0100 -> digit3 FF, digit2 7F, digit1 92, digit0 C0; BLANK_EN=0 -> digit3 C0, digit2 40.
REQ-033 LOAD 16'h5678 on exact boundary cycle -> next frame shows 5678, BUSY never asserts.
REQ-034 RESET pulse at digit 2 with BUSY high -> next cycle HEX_OUT FF, SEG_SELECT 1111, BUSY 0; scanning resumes at digit 0 showing 8'hC0.

Source files
------------

// File: rtl/multi_digit_display_driver_if.sv
// Host-side bus of the multiplexed hex display driver: load strobe, digit data,
// display controls, and the registered pin outputs coming back.
interface multi_digit_display_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digitIn;
  logic [NUM_DIGITS-1:0]   dotIn;
  logic [3:0]              brightness;
  logic                    blankEn;
  logic                    busy;
  logic [7:0]              hexOut;
  logic [NUM_DIGITS-1:0]   segSelect;

  modport master (
    output load, digitIn, dotIn, brightness, blankEn,
    input  busy, hexOut, segSelect
  );

  modport slave (
    input  load, digitIn, dotIn, brightness, blankEn,
    output busy, hexOut, segSelect
  );
endinterface

// File: rtl/multi_digit_display_driver.sv
// Time-multiplexed hex display driver with frame-synchronous loading and PWM brightness.
// Define LEADING_ZERO_BLANK_EN to build in run-time leading-zero blanking (BLANK_EN).
module multi_digit_display_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int SUBSLOT_DIV = 390
) (
  input  logic                        clk,
  input  logic                        rst,
  multi_digit_display_driver_if.slave bus
);

  localparam int SubW  = (SUBSLOT_DIV > 1) ? $clog2(SUBSLOT_DIV) : 1;
  localparam int IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DataW = 4 * NUM_DIGITS;
  localparam logic [SubW-1:0] SubMax = SubW'(SUBSLOT_DIV - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(NUM_DIGITS - 1);

  typedef enum logic {
    StIdle,
    StPending
  } loadState_t;

  logic [SubW-1:0]       subCntQ, subCntD;
  logic [3:0]            subPhaseQ, subPhaseD;
  logic [IdxW-1:0]       digitIdxQ, digitIdxD;
  loadState_t            stateQ, stateD;
  logic [DataW-1:0]      pendDigitsQ, pendDigitsD;
  logic [DataW-1:0]      dispDigitsQ, dispDigitsD;
  logic [NUM_DIGITS-1:0] pendDotsQ, pendDotsD;
  logic [NUM_DIGITS-1:0] dispDotsQ, dispDotsD;
  logic [7:0]            hexOutQ, hexOutD;
  logic [NUM_DIGITS-1:0] segSelQ, segSelD;

  logic                  slotTick;
  logic                  frameEnd;
  logic [3:0]            curNibble;
  logic                  curDot;
  logic                  curBlank;
  logic [NUM_DIGITS-1:0] curOneHot;

  function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      subCntQ     <= '0;
      subPhaseQ   <= '0;
      digitIdxQ   <= '0;
      stateQ      <= StIdle;
      pendDigitsQ <= '0;
      pendDotsQ   <= '0;
      dispDigitsQ <= '0;
      dispDotsQ   <= '0;
      hexOutQ     <= 8'hFF;
      segSelQ     <= '1;
    end else begin
      subCntQ     <= subCntD;
      subPhaseQ   <= subPhaseD;
      digitIdxQ   <= digitIdxD;
      stateQ      <= stateD;
      pendDigitsQ <= pendDigitsD;
      pendDotsQ   <= pendDotsD;
      dispDigitsQ <= dispDigitsD;
      dispDotsQ   <= dispDotsD;
      hexOutQ     <= hexOutD;
      segSelQ     <= segSelD;
    end
  end

  // The prescaler is kept as (sub-phase, count within sub-phase) so no divider is needed.
  always_comb begin
    slotTick  = (subPhaseQ == 4'hF) && (subCntQ == SubMax);
    frameEnd  = slotTick && (digitIdxQ == IdxMax);
    subCntD   = subCntQ + SubW'(1);
    subPhaseD = subPhaseQ;
    digitIdxD = digitIdxQ;
    if (subCntQ == SubMax) begin
      subCntD   = '0;
      subPhaseD = subPhaseQ + 4'd1;
    end
    if (slotTick) begin
      digitIdxD = (digitIdxQ == IdxMax) ? '0 : digitIdxQ + IdxW'(1);
    end
  end

  always_comb begin
    stateD      = stateQ;
    pendDigitsD = pendDigitsQ;
    pendDotsD   = pendDotsQ;
    dispDigitsD = dispDigitsQ;
    dispDotsD   = dispDotsQ;
    if (frameEnd) begin
      // A load landing on the boundary itself bypasses the pending register.
      if (bus.load) begin
        dispDigitsD = bus.digitIn;
        dispDotsD   = bus.dotIn;
      end else if (stateQ == StPending) begin
        dispDigitsD = pendDigitsQ;
        dispDotsD   = pendDotsQ;
      end
      stateD = StIdle;
    end else if (bus.load) begin
      pendDigitsD = bus.digitIn;
      pendDotsD   = bus.dotIn;
      stateD      = StPending;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] zeroFromHere;

  always_comb begin
    zeroFromHere = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      zeroFromHere[k] = ((dispDigitsQ >> (4 * k)) == '0);
    end
  end
`else
  logic unusedBlankEn;
  assign unusedBlankEn = bus.blankEn;
`endif

  always_comb begin
    curNibble = '0;
    curDot    = 1'b0;
    curBlank  = 1'b0;
    curOneHot = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digitIdxQ == IdxW'(k)) begin
        curNibble    = dispDigitsQ[4*k +: 4];
        curDot       = dispDotsQ[k];
        curOneHot[k] = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        curBlank     = bus.blankEn && (k != 0) && zeroFromHere[k];
`endif
      end
    end
    hexOutD = {~curDot, curBlank ? 7'h7F : hexToSeg(curNibble)};
    segSelD = (subPhaseQ <= bus.brightness) ? ~curOneHot : '1;
  end

  assign bus.busy      = (stateQ == StPending);
  assign bus.hexOut    = hexOutQ;
  assign bus.segSelect = segSelQ;

endmodule

// File: tb/tb_multi_digit_display_driver.sv
// Self-checking bench: frame-position model checked every cycle, plus directed literal checks.
module tb_multi_digit_display_driver;

  localparam int NumDigits = 4;
  localparam int SubDiv    = 2;
  localparam int SlotLen   = 16 * SubDiv;
  localparam int FrameLen  = NumDigits * SlotLen;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  multi_digit_display_driver_if #(.NUM_DIGITS(NumDigits)) bus ();

  multi_digit_display_driver #(
    .NUM_DIGITS (NumDigits),
    .SUBSLOT_DIV(SubDiv)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] expectedSegs(input logic [3:0] n);
    logic [6:0] table16 [16];
    table16 = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return table16[n];
  endfunction

  // Model: position within the frame since reset, plus the displayed/pending values.
  int          framePos = 0;
  logic [15:0] mDisp, mPend;
  logic [3:0]  mDot, mPendDot;
  logic        mBusy;
  logic        modelValid = 1'b0;
  logic [7:0]  expHex;
  logic [3:0]  expSeg;

  always @(posedge clk) begin : modelProc
    int         digit;
    int         sub;
    logic [3:0] nib;
    logic       blank;
    if (rst) begin
      framePos   = 0;
      mDisp      = '0;
      mPend      = '0;
      mDot       = '0;
      mPendDot   = '0;
      mBusy      = 1'b0;
      expHex     = 8'hFF;
      expSeg     = 4'hF;
      modelValid = 1'b1;
    end else if (modelValid) begin
      digit = framePos / SlotLen;
      sub   = (framePos % SlotLen) / SubDiv;
      nib   = 4'((mDisp >> (4 * digit)) & 16'hF);
      blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blank = bus.blankEn && (digit != 0) && ((mDisp >> (4 * digit)) == 16'h0);
`endif
      expHex = {~mDot[digit], blank ? 7'h7F : expectedSegs(nib)};
      expSeg = (sub <= int'(bus.brightness)) ? ~(4'b0001 << digit) : 4'hF;
      if (framePos == FrameLen - 1) begin
        if (bus.load) begin
          mDisp = bus.digitIn;
          mDot  = bus.dotIn;
        end else if (mBusy) begin
          mDisp = mPend;
          mDot  = mPendDot;
        end
        mBusy = 1'b0;
      end else if (bus.load) begin
        mPend    = bus.digitIn;
        mPendDot = bus.dotIn;
        mBusy    = 1'b1;
      end
      framePos = (framePos + 1) % FrameLen;
    end
  end

  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("modelHexOut", 32'(bus.hexOut), 32'(expHex));
      checkOutput("modelSegSelect", 32'(bus.segSelect), 32'(expSeg));
      checkOutput("modelBusy", 32'(bus.busy), 32'(mBusy));
    end
  end

  task automatic waitPos(input int p);
    int n = 0;
    while (framePos != p && n < 2 * FrameLen) begin
      @(negedge clk);
      n++;
    end
    if (framePos != p) checkOutput("waitPosTimeout", 32'(framePos), 32'(p));
  endtask

  // Called at a negedge: holds the load strobe for exactly one rising edge.
  task automatic applyStimulus(input logic [15:0] digits, input logic [3:0] dots);
    bus.load    = 1'b1;
    bus.digitIn = digits;
    bus.dotIn   = dots;
    @(negedge clk);
    bus.load    = 1'b0;
  endtask

  task automatic checkDigit(input int d, input logic [7:0] hexExp, input logic [3:0] segExp);
    waitPos(d * SlotLen + 3);
    checkOutput($sformatf("digit%0dHex", d), 32'(bus.hexOut), 32'(hexExp));
    checkOutput($sformatf("digit%0dSel", d), 32'(bus.segSelect), 32'(segExp));
  endtask

  task automatic countAnode(input logic [31:0] expCount);
    int n = 0;
    waitPos(1);
    for (int i = 0; i < SlotLen; i++) begin
      if (bus.segSelect == 4'b1110) n++;
      @(negedge clk);
    end
    checkOutput("anodeLowCycles", 32'(n), expCount);
  endtask

  initial begin : mainProc
    int busyHigh;
    rst            = 1'b1;
    bus.load       = 1'b0;
    bus.digitIn    = '0;
    bus.dotIn      = '0;
    bus.brightness = 4'd15;
    bus.blankEn    = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("resetHex", 32'(bus.hexOut), 32'h0FF);
    checkOutput("resetSel", 32'(bus.segSelect), 32'hF);
    checkOutput("resetBusy", 32'(bus.busy), 32'h0);
    rst = 1'b0;

    waitPos(10);
    applyStimulus(16'h1234, 4'b0000);
    checkOutput("busyAfterLoad", 32'(bus.busy), 32'h1);
    waitPos(0);
    checkOutput("busyAfterBoundary", 32'(bus.busy), 32'h0);
    checkDigit(0, 8'h99, 4'b1110);
    checkDigit(1, 8'hB0, 4'b1101);
    checkDigit(2, 8'hA4, 4'b1011);
    checkDigit(3, 8'hF9, 4'b0111);
    countAnode(32);

    waitPos(SlotLen + 16);
    applyStimulus(16'hABCD, 4'b0000);
    checkOutput("busyMidFrame", 32'(bus.busy), 32'h1);
    checkOutput("noTearDigit1", 32'(bus.hexOut), 32'h0B0);
    checkDigit(2, 8'hA4, 4'b1011);
    checkDigit(3, 8'hF9, 4'b0111);
    waitPos(0);
    checkOutput("busyClearedAtFrame", 32'(bus.busy), 32'h0);
    checkDigit(0, 8'hA1, 4'b1110);
    checkDigit(1, 8'hC6, 4'b1101);
    checkDigit(2, 8'h83, 4'b1011);
    checkDigit(3, 8'h88, 4'b0111);

    bus.brightness = 4'd3;
    countAnode(8);
    waitPos(20);
    checkOutput("dimHexValid", 32'(bus.hexOut), 32'h0A1);
    checkOutput("dimAnodeOff", 32'(bus.segSelect), 32'hF);
    bus.brightness = 4'd15;

    waitPos(FrameLen - 1);
    applyStimulus(16'h5678, 4'b0000);
    checkOutput("boundaryLoadBusy", 32'(bus.busy), 32'h0);
    busyHigh = 0;
    for (int i = 0; i < FrameLen; i++) begin
      if (bus.busy) busyHigh++;
      @(negedge clk);
    end
    checkOutput("boundaryLoadBusyNever", 32'(busyHigh), 32'h0);
    checkDigit(0, 8'h80, 4'b1110);
    checkDigit(1, 8'hF8, 4'b1101);
    checkDigit(2, 8'h82, 4'b1011);
    checkDigit(3, 8'h92, 4'b0111);

    waitPos(5);
    applyStimulus(16'h0050, 4'b0100);
    bus.blankEn = 1'b1;
    waitPos(0);
`ifdef LEADING_ZERO_BLANK_EN
    checkDigit(3, 8'hFF, 4'b0111);
    checkDigit(2, 8'h7F, 4'b1011);
`else
    checkDigit(3, 8'hC0, 4'b0111);
    checkDigit(2, 8'h40, 4'b1011);
`endif
    checkDigit(1, 8'h92, 4'b1101);
    checkDigit(0, 8'hC0, 4'b1110);
    bus.blankEn = 1'b0;
    waitPos(0);
    checkDigit(3, 8'hC0, 4'b0111);
    checkDigit(2, 8'h40, 4'b1011);

    waitPos(40);
    applyStimulus(16'h9999, 4'b1111);
    waitPos(2 * SlotLen + 5);
    checkOutput("busyBeforeReset", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midResetHex", 32'(bus.hexOut), 32'h0FF);
    checkOutput("midResetSel", 32'(bus.segSelect), 32'hF);
    checkOutput("midResetBusy", 32'(bus.busy), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("restartHex", 32'(bus.hexOut), 32'h0C0);
    checkOutput("restartSel", 32'(bus.segSelect), 32'hE);
    waitPos(0);
    checkOutput("pendingDiscarded", 32'(bus.busy), 32'h0);
    checkDigit(1, 8'hC0, 4'b1101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    compared++;
    mismatched++;
    $display("[TB] FAIL watchdog: simulation time exceeded, got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
